// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned ADDR_W_DEF  = 64;
    localparam int unsigned INSTR_W_DEF = 32;
    localparam int unsigned INSTR_BYTES = INSTR_W_DEF / 8;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  pc;
        logic [INSTR_W_DEF-1:0] instr;
        logic                   fault;
    } fetch_entry_t;

    function automatic int unsigned instr_bytes(input int unsigned instr_w);
        return instr_w / 8;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO with flush and a registered head entry, so the
// consumer sees head data and valid straight from flops.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned CntW   = cnt_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  entry_t          push_data_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic [CntW-1:0] count_o,
    output entry_t          head_o,
    output logic            head_valid_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [CntW-1:0]   cnt_after_pop;
    entry_t            head_q, head_d;
    logic              head_valid_q, head_valid_d;
    logic              do_pop;

    assign do_pop = pop_i && head_valid_q;

    always_comb begin
        mem_d         = mem_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        head_d        = '0;
        head_valid_d  = 1'b0;
        cnt_after_pop = count_q - CntW'(do_pop);
        if (push_i && !flush_i) begin
            mem_d[wr_ptr_q] = push_data_i;
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d     = rd_ptr_q + PtrW'(do_pop);
            wr_ptr_d     = wr_ptr_q + PtrW'(push_i);
            count_d      = cnt_after_pop + CntW'(push_i);
            head_valid_d = (count_d != '0);
            // Surviving entries start at the new read pointer; an empty queue
            // takes its head straight from the incoming push.
            if (cnt_after_pop != '0) begin
                head_d = mem_q[rd_ptr_d];
            end else if (push_i) begin
                head_d = push_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
        end
    end

    assign count_o      = count_q;
    assign head_o       = head_q;
    assign head_valid_o = head_valid_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with prefetch queue, single outstanding bus read.
// Define IFU_MISALIGN_CHECK_EN to turn misaligned fetch PCs into fault entries.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [ADDR_W-1:0]  req_addr,
    input  logic               resp_valid,
    input  logic [INSTR_W-1:0] resp_data,
    input  logic               resp_err,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_fault
);

    localparam int unsigned       Bytes   = instr_bytes(INSTR_W);
    localparam int unsigned       CntW    = cnt_width(DEPTH);
    localparam logic [ADDR_W-1:0] PcStep  = ADDR_W'(Bytes);
    localparam logic [ADDR_W-1:0] OffMask = ADDR_W'(Bytes - 1);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               fault;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_valid_q, req_valid_d;
    logic              outstanding_q, outstanding_d;
    logic              stale_q, stale_d;
    logic              halted_q, halted_d;

    logic              accept, req_hold, issue, pop, push, flush;
    logic [CntW-1:0]   count, count_after_pop, count_next;
    entry_t            push_data, head;
    logic              head_valid;

    assign accept          = req_valid_q && req_ready;
    assign req_hold        = req_valid_q && !req_ready;
    assign pop             = head_valid && instr_ready;
    assign count_after_pop = count - CntW'(pop);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        outstanding_d = outstanding_q;
        stale_d       = stale_q;
        halted_d      = halted_q;
        push          = 1'b0;
        push_data     = '0;
        flush         = redirect_valid;

        if (accept) begin
            outstanding_d = 1'b1;
            inflight_pc_d = req_addr_q;
            // A stale request was issued for the old stream; fetch_pc already
            // points at the redirect target.
            if (!stale_q) begin
                fetch_pc_d = fetch_pc_q + PcStep;
            end
        end

        if (resp_valid) begin
            outstanding_d = 1'b0;
            if (stale_q) begin
                stale_d = 1'b0;
            end else if (!redirect_valid) begin
                push            = 1'b1;
                push_data.pc    = inflight_pc_q;
                push_data.instr = resp_data;
                push_data.fault = resp_err;
                if (resp_err) begin
                    halted_d = 1'b1;
                end
            end
        end

`ifdef IFU_MISALIGN_CHECK_EN
        if (!redirect_valid && !req_valid_q && !outstanding_q && !halted_q &&
            ((fetch_pc_q & OffMask) != '0) && (count_after_pop < CntW'(DEPTH))) begin
            push            = 1'b1;
            push_data.pc    = fetch_pc_q;
            push_data.instr = '0;
            push_data.fault = 1'b1;
            halted_d        = 1'b1;
        end
`endif

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            // A response arriving now is dropped outright and needs no marker.
            stale_d    = req_valid_q || (outstanding_q && !resp_valid);
        end

        count_next = flush ? '0 : count_after_pop + CntW'(push);

        // Decide on next-state values so a new request can follow a response
        // back to back.
        issue = !req_hold && !outstanding_d && !halted_d && (count_next < CntW'(DEPTH));
`ifdef IFU_MISALIGN_CHECK_EN
        issue = issue && ((fetch_pc_d & OffMask) == '0);
`endif
        req_valid_d = req_hold || issue;
        req_addr_d  = issue ? (fetch_pc_d & ~OffMask) : req_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            req_addr_q    <= RESET_PC;
            req_valid_q   <= 1'b0;
            outstanding_q <= 1'b0;
            stale_q       <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            req_addr_q    <= req_addr_d;
            req_valid_q   <= req_valid_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
            halted_q      <= halted_d;
        end
    end

    ifu_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .flush_i      (flush),
        .count_o      (count),
        .head_o       (head),
        .head_valid_o (head_valid)
    );

    assign req_valid   = req_valid_q;
    assign req_addr    = req_addr_q;
    assign instr_valid = head_valid;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign instr_fault = head.fault;

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction fetch unit with a prefetch queue. It sits between the core's PC/redirect logic and the memory read port. It generates sequential fetch addresses on its own and keeps up to DEPTH fetched instructions buffered. It hands them downstream over a valid/ready handshake, and a redirect flushes the queue and drops any stale in-flight fetch.

## Interface
Parameters:
- ADDR_W, 64, fetch address / PC width
- INSTR_W, 32, instruction width; PC increment is INSTR_W/8
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_PC, 64'h8000_0000, first fetch address after reset

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- req_valid  out  1  memory read request valid
- req_ready  in  1  memory accepts request
- req_addr  out  ADDR_W  request address
- resp_valid  in  1  read data valid; always accepted, no backpressure
- resp_data  in  INSTR_W  fetched instruction
- resp_err  in  1  bus error on this read
- instr_valid  out  1  queue head valid
- instr_ready  in  1  downstream consumes head
- instr  out  INSTR_W  head instruction
- instr_pc  out  ADDR_W  head PC
- instr_fault  out  1  head carries a fetch fault

## Operation
- State: fetch_pc, outstanding (0/1), stale (1 bit), halted (1 bit), queue count 0..DEPTH.
- Only one request is in flight at a time. A new request issues when:
  - outstanding=0 and halted=0, and
  - count + outstanding < DEPTH, counted after this cycle's pop.
- Request rules:
  - On issue, req_valid rises with req_addr=fetch_pc.
  - req_valid and req_addr stay stable until req_valid&&req_ready.
  - On acceptance: outstanding=1 and fetch_pc += INSTR_W/8. Wrap-around modulo 2^ADDR_W is legal.
- Response rules:
  - On resp_valid with stale=0, push {pc, resp_data, resp_err}. The pc is the accepted req_addr.
  - outstanding clears on any resp_valid.
  - If resp_err=1, halted sets: no further requests until a redirect.
- Redirect:
  - fetch_pc=redirect_pc, queue emptied, halted cleared.
  - If a request is outstanding or pending unaccepted, stale=1. The next response is dropped and stale clears with it.
  - A pending unaccepted request is still held stable until accepted, and is then treated as stale.
- Simultaneous events:
  - Pop and push in the same cycle at count=DEPTH is legal, but cannot occur by construction since count+outstanding ≤ DEPTH.
  - Redirect in the same cycle as a pop: the transfer completes and all remaining entries are flushed.
  - Redirect in the same cycle as resp_valid: the response is dropped and stale is not set for it.
- Reset mid-operation:
  - Queue empty, outstanding=0, stale=0, halted=0, fetch_pc=RESET_PC.
  - The bus side must not return a response for a pre-reset request.

## Timing
- Reset values:
  - req_valid=0, req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, instr_fault=0.
  - Count=0 and fetch_pc=RESET_PC.
- First req_valid is in the first cycle after rst deasserts.
- resp_valid in cycle N gives instr_valid in cycle N+1. There is no combinational bypass.
- After a redirect in cycle N:
  - instr_valid=0 in N+1.
  - If nothing is in flight, req_valid with the new address in N+1.
- Steady state with a zero-wait memory (req_ready=1, response the cycle after acceptance) sustains one instruction per 2 cycles.
- All outputs are registered or driven directly from registers.

## Configuration
- IFU_MISALIGN_CHECK_EN defined:
  - When fetch_pc is not INSTR_W/8-aligned at issue time, no bus request is made.
  - A fault entry {fetch_pc, instr=0, fault=1} is pushed and halted sets.
- Undefined:
  - No check is made; req_addr low log2(INSTR_W/8) bits are forced to 0.
  - instr_fault reflects resp_err only.

## Structure
- Package ifu_pkg:
  - fetch entry struct {pc, instr, fault}
  - INSTR_BYTES constant
  - NOP encoding (32'h0000_0013)
- Sub-module ifu_fifo: synchronous FIFO, DEPTH×entry, with push, pop, flush and count outputs, and registered head.

## Test plan
- Reset, then req_ready=1 with one-cycle responses → requests at 0x8000_0000, _0004, _0008…; instr_pc matches each request; one instruction every 2 cycles.
- instr_ready=0 with DEPTH=4 → exactly 4 requests issued, then req_valid stays 0; a single pop allows exactly one new request.
- Redirect to 0x8000_1000 while a request to 0x8000_0010 is outstanding → that response is dropped, the queue is empty, and the next instr_pc=0x8000_1000.
- req_ready=0 for 5 cycles, with a redirect in cycle 2 → req_addr is held stable until acceptance, the result is discarded, then a fetch at the redirect target.
- resp_err=1 on 0x8000_0008 → entry presented with instr_fault=1, no further requests; a redirect resumes fetching.
- IFU_MISALIGN_CHECK_EN defined, redirect to 0x8000_0002 → no bus request; fault entry with instr_pc=0x8000_0002 and instr=0.
